// File: rtl/parking_allocator.sv
// parking_allocator: per-class occupancy tracking against per-class capacity
// registers that share one lot-wide limit. Entries use a valid/ready handshake
// and get a registered grant/deny one cycle later; exits are fire-and-forget.
module parking_allocator #(
  parameter int NUM_CLASSES = 2,
  parameter int CLS_W       = 1,
  parameter int CNT_W       = 16,
  parameter int TOTAL_CAP   = 700,
  parameter int OPEN_HOUR   = 8,
  parameter logic [NUM_CLASSES*CNT_W-1:0] CAP_INIT = {16'd200, 16'd500}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   hour,
  input  logic                         cfg_we,
  input  logic [CLS_W-1:0]             cfg_class,
  input  logic [CNT_W-1:0]             cfg_cap,
  output logic                         cfg_err,
  input  logic                         in_valid,
  input  logic [CLS_W-1:0]             in_class,
  output logic                         in_ready,
  output logic                         resp_valid,
  output logic                         resp_grant,
  input  logic                         out_valid,
  input  logic [CLS_W-1:0]             out_class,
  output logic [NUM_CLASSES*CNT_W-1:0] occ,
  output logic [NUM_CLASSES*CNT_W-1:0] free,
  output logic [NUM_CLASSES-1:0]       full,
  output logic [CNT_W-1:0]             total_occ,
  output logic                         exit_err
);

  // Wide enough to hold the sum of every capacity plus the candidate value.
  localparam int SUM_W = CNT_W + $clog2(NUM_CLASSES + 1) + 1;

  logic [CNT_W-1:0] r_cap [NUM_CLASSES];
  logic [CNT_W-1:0] r_occ [NUM_CLASSES];
  logic [CNT_W-1:0] r_total;
  logic             r_resp_valid;
  logic             r_resp_grant;
  logic             r_cfg_err;
  logic             r_exit_err;

  logic [NUM_CLASSES-1:0] w_in_oh;
  logic [NUM_CLASSES-1:0] w_out_oh;
  logic [NUM_CLASSES-1:0] w_cfg_oh;
  logic [CNT_W-1:0]       w_occ_x [NUM_CLASSES];
  logic [CNT_W-1:0]       w_total_x;
  logic [SUM_W-1:0]       w_cap_sum;
  logic                   w_exit_ok;
  logic                   w_room;
  logic                   w_accept;
  logic                   w_grant;
  logic                   w_cfg_ok;

  // Configuration has priority: entries stall while a capacity write is presented.
  assign in_ready = !cfg_we;
  assign w_accept = in_valid && in_ready;

  // Decode class indices to one-hot; an out-of-range index decodes to all zeros.
  always_comb begin
    w_in_oh  = '0;
    w_out_oh = '0;
    w_cfg_oh = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      w_in_oh[i]  = (in_class  == CLS_W'(i));
      w_out_oh[i] = (out_class == CLS_W'(i));
      w_cfg_oh[i] = (cfg_class == CLS_W'(i));
    end
  end

  // Exit handling and post-exit occupancy, which the entry decision is based on.
  always_comb begin
    w_exit_ok = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      w_exit_ok = w_exit_ok | (w_out_oh[i] & (r_occ[i] != {CNT_W{1'b0}}));
    end
    w_exit_ok = w_exit_ok & out_valid;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      w_occ_x[i] = r_occ[i] - CNT_W'(w_exit_ok & w_out_oh[i]);
    end
    w_total_x = r_total - CNT_W'(w_exit_ok);
  end

  // Entry decision: lot open, class has room, lot has room (all after same-cycle exit).
  always_comb begin
    w_room = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      w_room = w_room | (w_in_oh[i] & (w_occ_x[i] < r_cap[i]));
    end
    w_grant = w_accept && (hour >= 5'(OPEN_HOUR)) && w_room &&
              (w_total_x < CNT_W'(TOTAL_CAP));
  end

  // Capacity write check: the other classes' capacities plus the new one must fit the lot.
  always_comb begin
    w_cap_sum = SUM_W'(cfg_cap);
    for (int i = 0; i < NUM_CLASSES; i++) begin
      w_cap_sum = w_cap_sum + (w_cfg_oh[i] ? {SUM_W{1'b0}} : SUM_W'(r_cap[i]));
    end
    w_cfg_ok = cfg_we && (|w_cfg_oh) && (w_cap_sum <= SUM_W'(TOTAL_CAP));
  end

  // State update: occupancy, totals, capacities and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_cap[i] <= CAP_INIT[i*CNT_W +: CNT_W];
        r_occ[i] <= {CNT_W{1'b0}};
      end
      r_total      <= {CNT_W{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_grant <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_exit_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_occ[i] <= w_occ_x[i] + CNT_W'(w_grant & w_in_oh[i]);
        if (w_cfg_ok && w_cfg_oh[i]) begin
          r_cap[i] <= cfg_cap;
        end
      end
      r_total      <= w_total_x + CNT_W'(w_grant);
      r_resp_valid <= w_accept;
      r_resp_grant <= w_grant;
      r_cfg_err    <= cfg_we && !w_cfg_ok;
      r_exit_err   <= out_valid && !w_exit_ok;
    end
  end

  // Flatten per-class state; free clamps at zero when capacity shrank below occupancy.
  always_comb begin
    occ  = '0;
    free = '0;
    full = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      occ[i*CNT_W +: CNT_W]  = r_occ[i];
      free[i*CNT_W +: CNT_W] = (r_cap[i] > r_occ[i]) ? (r_cap[i] - r_occ[i]) : {CNT_W{1'b0}};
      full[i]                = (r_occ[i] >= r_cap[i]);
    end
  end

  assign total_occ  = r_total;
  assign resp_valid = r_resp_valid;
  assign resp_grant = r_resp_grant;
  assign cfg_err    = r_cfg_err;
  assign exit_err   = r_exit_err;

endmodule

// File: doc/parking_allocator.md
# parking_allocator

Parametrised, fully synchronous successor to the hourly parking controller. It tracks occupancy for NUM_CLASSES vehicle classes against per-class capacity registers, all sharing one lot limit. Entry requests use a valid/ready handshake and receive a registered grant/deny. The block sits between the gate sensors and the display/billing logic, and takes the current hour from the lot clock block.

## Interface
- NUM_CLASSES, 2: vehicle classes; class 0 = university, class 1 = general.
- CLS_W, 1: class index width, equal to $clog2(NUM_CLASSES) with a minimum of 1.
- CNT_W, 16: width of the occupancy and capacity counters.
- TOTAL_CAP, 700: lot-wide spot limit.
- OPEN_HOUR, 8: entries are denied while hour < OPEN_HOUR.
- CAP_INIT, {16'd200,16'd500}: flat NUM_CLASSES*CNT_W reset capacities; class 0 is in the LSBs.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hour  in  5  current hour, 0..23.
- cfg_we  in  1  capacity write strobe.
- cfg_class  in  CLS_W  target class of the capacity write.
- cfg_cap  in  CNT_W  new capacity value.
- cfg_err  out  1  one-cycle pulse: capacity write rejected.
- in_valid  in  1  entry request.
- in_class  in  CLS_W  class of the entering car.
- in_ready  out  1  entry request can be accepted this cycle.
- resp_valid  out  1  one-cycle pulse: entry decision is available.
- resp_grant  out  1  1 = barrier opens, 0 = denied; qualified by resp_valid.
- out_valid  in  1  exit event; fire-and-forget.
- out_class  in  CLS_W  class of the exiting car.
- occ  out  NUM_CLASSES*CNT_W  per-class occupancy, flat.
- free  out  NUM_CLASSES*CNT_W  per-class free spots, flat.
- full  out  NUM_CLASSES  per-class full flags.
- total_occ  out  CNT_W  sum of all class occupancies.
- exit_err  out  1  one-cycle pulse: exit arrived for an empty class.

## Operation
- State per class: cap[i] and occ[i].
- free[i] = cap[i] > occ[i] ? cap[i] - occ[i] : 0. This is combinational from registers and never goes negative.
- full[i] = (occ[i] >= cap[i]).
- Entry handshake:
  - A request is accepted when in_valid && in_ready.
  - in_ready = !cfg_we. Configuration writes take priority over entries.
- Grant condition, evaluated in the accept cycle, using the occupancy after that cycle's exit:
  - hour >= OPEN_HOUR
  - occ'[c] < cap[c]
  - total' < TOTAL_CAP
  - here occ' and total' already include a same-cycle exit.
- On grant, occ[c] and total_occ are incremented.
- Exit with occ[out_class] > 0: occ[out_class] and total_occ are decremented.
- Exit with occ[out_class] == 0: no change; exit_err pulses.
- Simultaneous exit and entry:
  - Same class: both are applied. Net occupancy is unchanged, and the entry is granted even if the class was full before the exit.
  - Different classes: both are applied independently.
- Capacity write:
  - The write is accepted only if the sum of cap[j] over j != cfg_class, plus cfg_cap, is <= TOTAL_CAP. Otherwise cap is unchanged and cfg_err pulses.
  - cfg_class >= NUM_CLASSES is rejected with cfg_err.
- Capacity shrink below occupancy:
  - Cars are never evicted.
  - free = 0 and full = 1 until exits bring occ below cap.
- Closed hours (hour < OPEN_HOUR):
  - All entries are denied.
  - Exits are still processed.
- Counters saturate. An increment never wraps, because grant requires occ < cap <= TOTAL_CAP, which is assumed to be < 2^CNT_W.
- in_class >= NUM_CLASSES is denied.
- out_class >= NUM_CLASSES is ignored and pulses exit_err.

## Timing
- Reset values:
  - occ = 0, total_occ = 0, cap = CAP_INIT.
  - resp_valid = 0, resp_grant = 0, cfg_err = 0, exit_err = 0.
  - in_ready follows !cfg_we.
  - free = CAP_INIT, full = 0 (for nonzero CAP_INIT).
- Entry latency:
  - Request accepted at edge N.
  - resp_valid/resp_grant asserted for exactly the cycle after edge N.
  - occ is updated at the same edge.
- Back-to-back requests are accepted every cycle. Each decision sees the occupancy updated by the previous grant.
- Exit updates are visible on occ/free/full one cycle after out_valid.
- cfg_err is registered, one cycle after cfg_we. A new cap is visible on the next cycle.
- rst assertion mid-transaction clears everything immediately. A pending resp_valid is dropped, and no grant is issued for an in-flight request.

## Test plan
- Reset, then hour=9: 500 class-0 entries. All are granted; occ[0]=500, full[0]=1. The 501st entry → resp_grant=0.
- hour=7: class-1 entry → denied, occ unchanged. Then exit with occ[1]=0 → exit_err pulse.
- occ[1]=200 (full): entry and exit of class 1 in the same cycle → grant=1, occ[1] stays 200.
- caps 500/200: cfg write cap[1]=250 → cfg_err=1, cap unchanged. Write cap[0]=450, then cap[1]=250 → both accepted.
- occ[0]=480, write cap[0]=400 → free[0]=0, full[0]=1. 80 exits → full[0]=0 after the 81st exit.
- Assert rst one cycle after an accepted entry → resp_valid stays 0, occ = 0, cap = CAP_INIT.
